// File: rtl/mix_core.sv
// Two-source gain/sum/saturate mixer; result held on mix_out for a full ws slot.
// Optional build macro MIX_HOLD_LAST_EN: a stale source reuses its last sample instead of contributing 0.
module mix_core #(
    parameter int unsigned DW        = 16,
    parameter int unsigned GW        = 4,
    parameter int unsigned GAIN_FRAC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ws,
    input  logic [DW-1:0] a_data,
    input  logic          a_valid,
    input  logic [DW-1:0] b_data,
    input  logic          b_valid,
    input  logic [GW-1:0] gain_a,
    input  logic [GW-1:0] gain_b,
    input  logic          sat_clr,
    output logic [DW-1:0] mix_out,
    output logic          mix_rdy,
    output logic          sat_flag,
    output logic          ovr_flag
);

    localparam int unsigned PW = DW + GW;
    localparam logic signed [PW:0] SAT_MAX = (PW+1)'(2**(DW-1) - 1);
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MULA, S_MULB, S_SUM} state_t;

    state_t               r_state;
    logic                 r_ws_q;
    logic [DW-1:0]        r_hold_a, r_hold_b;
    logic                 r_fa, r_fb;
    logic [DW-1:0]        r_snap_a, r_snap_b;
    logic [GW-1:0]        r_ga, r_gb;
    logic signed [PW-1:0] r_pa, r_pb;
    logic [DW-1:0]        r_mix_out;
    logic                 r_mix_rdy, r_sat, r_ovr;

    logic                 w_edge;
    logic [DW-1:0]        w_snap_a, w_snap_b;
    logic signed [PW:0]   w_op, w_gn, w_prod, w_sum;
    logic signed [PW-1:0] w_scaled;
    logic                 w_hi, w_lo;
    logic [DW-1:0]        w_clip;

    assign w_edge = ws ^ r_ws_q;

`ifdef MIX_HOLD_LAST_EN
    assign w_snap_a = r_fa ? r_hold_a : r_hold_a;
    assign w_snap_b = r_fb ? r_hold_b : r_hold_b;
`else
    assign w_snap_a = r_fa ? r_hold_a : '0;
    assign w_snap_b = r_fb ? r_hold_b : '0;
`endif

    // One shared multiplier: source A in MULA, source B in MULB
    always_comb begin
        w_op     = (r_state == S_MULB) ? {{(GW+1){r_snap_b[DW-1]}}, r_snap_b}
                                       : {{(GW+1){r_snap_a[DW-1]}}, r_snap_a};
        w_gn     = (r_state == S_MULB) ? {{(DW+1){1'b0}}, r_gb}
                                       : {{(DW+1){1'b0}}, r_ga};
        w_prod   = w_op * w_gn;
        w_scaled = PW'(w_prod >>> GAIN_FRAC);
        w_sum    = {r_pa[PW-1], r_pa} + {r_pb[PW-1], r_pb};
        w_hi     = (w_sum > SAT_MAX);
        w_lo     = (w_sum < SAT_MIN);
        if (w_hi)
            w_clip = {1'b0, {(DW-1){1'b1}}};
        else if (w_lo)
            w_clip = {1'b1, {(DW-1){1'b0}}};
        else
            w_clip = w_sum[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ws_q    <= 1'b0;
            r_hold_a  <= '0;
            r_hold_b  <= '0;
            r_fa      <= 1'b0;
            r_fb      <= 1'b0;
            r_snap_a  <= '0;
            r_snap_b  <= '0;
            r_ga      <= '0;
            r_gb      <= '0;
            r_pa      <= '0;
            r_pb      <= '0;
            r_mix_out <= '0;
            r_mix_rdy <= 1'b0;
            r_sat     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ws_q    <= ws;
            r_mix_rdy <= 1'b0;

            // A valid on the edge cycle belongs to the next slot
            if (a_valid) begin
                r_hold_a <= a_data;
                r_fa     <= 1'b1;
            end else if (w_edge) begin
                r_fa     <= 1'b0;
            end
            if (b_valid) begin
                r_hold_b <= b_data;
                r_fb     <= 1'b1;
            end else if (w_edge) begin
                r_fb     <= 1'b0;
            end

            if (sat_clr)
                r_sat <= 1'b0;

            if (w_edge) begin
                if (r_state != S_IDLE)
                    r_ovr <= 1'b1;
                r_snap_a <= w_snap_a;
                r_snap_b <= w_snap_b;
                r_ga     <= gain_a;
                r_gb     <= gain_b;
                r_state  <= S_MULA;
            end else begin
                case (r_state)
                    S_MULA: begin
                        r_pa    <= w_scaled;
                        r_state <= S_MULB;
                    end
                    S_MULB: begin
                        r_pb    <= w_scaled;
                        r_state <= S_SUM;
                    end
                    S_SUM: begin
                        r_mix_out <= w_clip;
                        r_mix_rdy <= 1'b1;
                        if (w_hi || w_lo)
                            r_sat <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mix_out  = r_mix_out;
    assign mix_rdy  = r_mix_rdy;
    assign sat_flag = r_sat;
    assign ovr_flag = r_ovr;

endmodule
